// File: rtl/phase_lag_pkg.sv
// Shared types and constants for the phase lag meter.
// The optional averaging build is enabled with the macro PHASE_LAG_AVG_EN.
package phase_lag_pkg;

    localparam int DEFAULT_CNT_W = 8;
    localparam int AVG_LOG2      = 2;

    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// SYNC_STAGES-deep synchronizer followed by one edge-detect flop.
// Produces the synchronized level and a single-cycle rise pulse.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: non-blocking assignments make every stage capture the old value of the one before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/phase_lag_meter.sv
// Measures the lag from ref_in rise to sig_in rise and the ref_in period, in clk cycles.
// Define PHASE_LAG_AVG_EN to report the truncated mean of every 4 valid measurements.
module phase_lag_meter
    import phase_lag_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_in,
    input  logic             sig_in,
    input  logic             clear,
    output logic             meas_valid,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             sig_missing,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

    logic ref_rise, sig_rise;
    logic ref_level_unused, sig_level_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ref_in),
        .level    (ref_level_unused),
        .rise     (ref_rise)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .level    (sig_level_unused),
        .rise     (sig_rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             sig_missing_q, sig_missing_d;
    logic             timeout_q, timeout_d;
    logic             close_ok;

`ifdef PHASE_LAG_AVG_EN
    localparam int SUM_W = CNT_W + AVG_LOG2;

    logic [SUM_W-1:0]    sum_ph_q, sum_ph_d;
    logic [SUM_W-1:0]    sum_per_q, sum_per_d;
    logic [AVG_LOG2-1:0] acc_cnt_q, acc_cnt_d;
    logic [SUM_W-1:0]    avg_ph, avg_per;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        seen_d        = seen_q;
        ph_d          = ph_q;
        phase_d       = phase_q;
        period_d      = period_q;
        meas_valid_d  = 1'b0;
        sig_missing_d = 1'b0;
        timeout_d     = 1'b0;
        close_ok      = 1'b0;

        if (ref_rise)               cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
        else                        cnt_d = cnt_q;

        if (clear) begin
            state_d = ARM;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (ref_rise) begin
                        state_d = MEASURE;
                        seen_d  = 1'b0;
                        ph_d    = '0;
                    end
                end
                MEASURE: begin
                    if (ref_rise) begin
                        // The closing rise also opens the next period; a coincident sig rise is phase 0.
                        if (cnt_q >= CNT_MIN) begin
                            close_ok      = seen_q;
                            sig_missing_d = ~seen_q;
                        end
                        seen_d = sig_rise;
                        ph_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                    end else if (sig_rise && !seen_q) begin
                        ph_d   = cnt_q;
                        seen_d = 1'b1;
                    end
                end
                default: state_d = ARM;
            endcase
        end

`ifdef PHASE_LAG_AVG_EN
        sum_ph_d  = sum_ph_q;
        sum_per_d = sum_per_q;
        acc_cnt_d = acc_cnt_q;
        avg_ph    = sum_ph_q + SUM_W'(ph_q);
        avg_per   = sum_per_q + SUM_W'(cnt_q);
        if (clear || sig_missing_d || timeout_d) begin
            sum_ph_d  = '0;
            sum_per_d = '0;
            acc_cnt_d = '0;
        end else if (close_ok) begin
            if (acc_cnt_q == '1) begin
                meas_valid_d = 1'b1;
                phase_d      = avg_ph[SUM_W-1:AVG_LOG2];
                period_d     = avg_per[SUM_W-1:AVG_LOG2];
                sum_ph_d     = '0;
                sum_per_d    = '0;
                acc_cnt_d    = '0;
            end else begin
                sum_ph_d  = avg_ph;
                sum_per_d = avg_per;
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
        end
`else
        if (close_ok) begin
            meas_valid_d = 1'b1;
            phase_d      = ph_q;
            period_d     = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARM;
            cnt_q         <= '0;
            ph_q          <= '0;
            seen_q        <= 1'b0;
            phase_q       <= '0;
            period_q      <= '0;
            meas_valid_q  <= 1'b0;
            sig_missing_q <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef PHASE_LAG_AVG_EN
            sum_ph_q      <= '0;
            sum_per_q     <= '0;
            acc_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ph_q          <= ph_d;
            seen_q        <= seen_d;
            phase_q       <= phase_d;
            period_q      <= period_d;
            meas_valid_q  <= meas_valid_d;
            sig_missing_q <= sig_missing_d;
            timeout_q     <= timeout_d;
`ifdef PHASE_LAG_AVG_EN
            sum_ph_q      <= sum_ph_d;
            sum_per_q     <= sum_per_d;
            acc_cnt_q     <= acc_cnt_d;
`endif
        end
    end

    assign meas_valid  = meas_valid_q;
    assign phase_cnt   = phase_q;
    assign period_cnt  = period_q;
    assign sig_missing = sig_missing_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q == MEASURE);

endmodule

// File: tb/tb_phase_lag_meter.sv
// Randomized and directed bench for phase_lag_meter with a pin-level reference model
// and a queue scoreboard; the model follows PHASE_LAG_AVG_EN when it is defined.
module tb_phase_lag_meter;

    localparam int CNT_W      = 8;
    localparam int MIN_PERIOD = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ref_in;
    logic             sig_in;
    logic             clear;
    logic             meas_valid;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             sig_missing;
    logic             timeout;
    logic             busy;

    phase_lag_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .MIN_PERIOD(MIN_PERIOD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_in      (ref_in),
        .sig_in      (sig_in),
        .clear       (clear),
        .meas_valid  (meas_valid),
        .phase_cnt   (phase_cnt),
        .period_cnt  (period_cnt),
        .sig_missing (sig_missing),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #2 clk = ~clk;

    typedef enum int {EV_VALID = 0, EV_MISSING = 1, EV_TIMEOUT = 2} ev_e;
    typedef struct {
        ev_e kind;
        int  phase;
        int  period;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: works on pin-edge cycle numbers; both inputs share the same sync latency.
    int  t = 0;
    bit  ref_hist[$];
    bit  prev_r = 1'b0, prev_s = 1'b0;
    bit  measuring = 1'b0, seen = 1'b0;
    int  r_prev = 0, ph = 0;
    int  last_phase = 0, last_period = 0;
    int  acc_n = 0, acc_ph = 0, acc_per = 0;

    function automatic void emit(input ev_e kind);
        exp_t e;
        e.kind   = kind;
        e.phase  = last_phase;
        e.period = last_period;
        exp_q.push_back(e);
    endfunction

    function automatic void report_valid(input int p, input int per);
`ifdef PHASE_LAG_AVG_EN
        acc_n++;
        acc_ph  += p;
        acc_per += per;
        if (acc_n == 4) begin
            last_phase  = acc_ph / 4;
            last_period = acc_per / 4;
            acc_n = 0; acc_ph = 0; acc_per = 0;
            emit(EV_VALID);
        end
`else
        last_phase  = p;
        last_period = per;
        emit(EV_VALID);
`endif
    endfunction

    function automatic void reset_acc();
        acc_n = 0; acc_ph = 0; acc_per = 0;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit clr);
        bit rr, sr;
        int per;
        rr = r & ~prev_r;
        sr = s & ~prev_s;
        prev_r = r;
        prev_s = s;
        if (clr) begin
            measuring = 1'b0;
            reset_acc();
        end else if (!measuring) begin
            if (rr) begin
                measuring = 1'b1;
                r_prev    = t;
                seen      = 1'b0;
            end
        end else if (rr) begin
            per = t - r_prev;
            if (per >= MIN_PERIOD) begin
                if (seen) report_valid(ph, per);
                else begin
                    reset_acc();
                    emit(EV_MISSING);
                end
            end
            r_prev = t;
            seen   = sr;
            ph     = 0;
        end else if (t - r_prev == CNT_MAX) begin
            reset_acc();
            emit(EV_TIMEOUT);
            measuring = 1'b0;
        end else if (sr && !seen) begin
            seen = 1'b1;
            ph   = t - r_prev;
        end
    endfunction

    function automatic void model_reset();
        measuring   = 1'b0;
        last_phase  = 0;
        last_period = 0;
        reset_acc();
    endfunction

    task automatic tick(input bit r, input bit s, input bit clr);
        @(negedge clk);
        ref_in = r;
        sig_in = s;
        clear  = clr;
        ref_hist.push_back(r);
        model_step(r, s, clr);
        t++;
    endtask

    // sig_in is ref_in delayed by lag cycles (or held low); clear pulses at index clr_at.
    int ph_pos = 0;
    task automatic gen(input int per, input int hi, input int lag, input bit sig_en,
                       input int n, input int clr_at);
        bit r, s;
        for (int i = 0; i < n; i++) begin
            r = ((ph_pos % per) < hi);
            if (lag == 0)      s = r;
            else if (t >= lag) s = ref_hist[t - lag];
            else               s = 1'b0;
            ph_pos++;
            tick(r, s & sig_en, (i == clr_at));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_meas_valid"},  int'(meas_valid),  0);
        check({tag, "_sig_missing"}, int'(sig_missing), 0);
        check({tag, "_timeout"},     int'(timeout),     0);
        check({tag, "_phase_cnt"},   int'(phase_cnt),   0);
        check({tag, "_period_cnt"},  int'(period_cnt),  0);
        check({tag, "_busy"},        int'(busy),        0);
    endtask

    // Monitor: every result pulse pops one expected event and compares it.
    always @(negedge clk) begin
        int   np;
        int   kind_act;
        exp_t e;
        if (rst_n === 1'b1) begin
            np = int'(meas_valid) + int'(sig_missing) + int'(timeout);
            if (np > 0) begin
                check("pulse_exclusive", np, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", np, 0);
                end else begin
                    e = exp_q.pop_front();
                    kind_act = meas_valid ? 0 : (sig_missing ? 1 : 2);
                    check("event_kind", kind_act, int'(e.kind));
                    check("phase_cnt", int'(phase_cnt), e.phase);
                    check("period_cnt", int'(period_cnt), e.period);
                end
            end
        end
    end

    initial begin
        int per, hi, lag, nper;
        bit sen;

        rst_n  = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        clear  = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        check_idle("reset");
        rst_n = 1'b1;

        // 90 degree lag, then coincident rises, then one cycle short of a full period.
        ph_pos = 0;
        gen(120, 60, 30, 1'b1, 600, -1);
        check("busy_measuring", int'(busy), 1);
        gen(120, 60, 0, 1'b1, 600, -1);
        gen(120, 60, 119, 1'b1, 600, -1);

        // sig held low: sig_missing every period, data outputs held.
        gen(120, 60, 0, 1'b0, 480, -1);

        // ref stops after one rise: timeout, back to ARM, then lag 10 measurements.
        ph_pos = 0;
        gen(1000, 60, 10, 1'b1, 400, -1);
        check("busy_after_timeout", int'(busy), 0);
        ph_pos = 0;
        gen(120, 60, 10, 1'b1, 360, -1);

        // clear mid-period, well away from any edge.
        ph_pos = 0;
        gen(120, 60, 30, 1'b1, 600, 285);

        // Asynchronous reset while both waves are low.
        gen(120, 60, 30, 1'b1, 95, -1);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_idle("async_reset");
        gen(120, 60, 30, 1'b1, 5, -1);
        rst_n = 1'b1;
        check_idle("after_reset");
        gen(120, 60, 30, 1'b1, 380, -1);

        // Glitch periods below MIN_PERIOD are discarded.
        ph_pos = 0;
        gen(2, 1, 0, 1'b1, 6, -1);
        ph_pos = 0;
        gen(120, 60, 40, 1'b1, 480, -1);

        for (int k = 0; k < 10; k++) begin
            per  = $urandom_range(270, 2);
            hi   = $urandom_range(per - 1, 1);
            lag  = $urandom_range(per + 5, 0);
            sen  = ($urandom_range(3, 0) != 0);
            nper = $urandom_range(5, 2);
            ph_pos = 0;
            gen(per, hi, lag, sen, per * nper, -1);
        end

        // Idle tail lets any open measurement time out and all results drain.
        gen(1000, 0, 0, 1'b0, 300, -1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
